// File: rtl/div_iter_pkg.sv
// Shared encodings for the iterative divider: operation codes, FSM states and op decode helpers.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivOpDiv  = 2'b00,
    DivOpDivu = 2'b01,
    DivOpRem  = 2'b10,
    DivOpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DivIdle  = 2'b00,
    DivCalc  = 2'b01,
    DivFixup = 2'b10,
    DivDone  = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DivOpDiv) || (op == DivOpRem);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == DivOpRem) || (op == DivOpRemu);
  endfunction

endpackage

// File: rtl/div_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module div_lzc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshakes and flush.
// Optional macro DIV_EARLY_OUT_EN: skip leading-zero dividend bits to shorten the iteration count.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            n_rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            annul_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_reg, state_next;

  logic [XLEN:0]    rem_reg;
  logic [XLEN-1:0]  quo_reg;
  logic [XLEN-1:0]  dvs_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rem_op_reg, neg_q_reg, neg_r_reg;
  logic [XLEN-1:0]  result_reg;

  logic            accept, sgn_in, rem_in, dvd_neg, dvs_neg;
  logic            div_zero, ovf, dvd_zero, special;
  logic [XLEN-1:0] dvd_mag, dvs_mag, special_result, load_dvd;
  logic [CNT_W-1:0] load_iter;

  assign accept   = valid_i & ready_o & ~annul_i;
  assign sgn_in   = op_is_signed(div_op_e'(op_i));
  assign rem_in   = op_is_rem(div_op_e'(op_i));
  assign dvd_neg  = sgn_in & dividend_i[XLEN-1];
  assign dvs_neg  = sgn_in & divisor_i[XLEN-1];
  assign dvd_mag  = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag  = dvs_neg ? -divisor_i : divisor_i;
  assign div_zero = (divisor_i == '0);
  assign ovf      = sgn_in & (dividend_i == MIN_NEG) & (&divisor_i);
  assign special  = div_zero | ovf | dvd_zero;

  always_comb begin
    special_result = '0;
    if (div_zero)  special_result = rem_in ? dividend_i : '1;
    else if (ovf)  special_result = rem_in ? '0 : dividend_i;
  end

`ifdef DIV_EARLY_OUT_EN
  localparam int LZC_W = $clog2(XLEN + 1);
  logic [LZC_W-1:0] lzc;

  div_lzc #(.WIDTH(XLEN), .CNT_W(LZC_W)) u_lzc (
    .data  (dvd_mag),
    .count (lzc)
  );

  assign dvd_zero = (dvd_mag == '0);

  // Pre-shift so exactly iters*BITS_PER_CYCLE significant bits remain to be consumed.
  always_comb begin
    int sig_bits;
    int iters;
    sig_bits  = XLEN - int'(lzc);
    iters     = (sig_bits + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    if (iters < 1) iters = 1;
    load_iter = CNT_W'(iters);
    load_dvd  = dvd_mag << (XLEN - iters * BITS_PER_CYCLE);
  end
`else
  assign dvd_zero  = 1'b0;
  assign load_iter = CNT_W'(ITER);
  assign load_dvd  = dvd_mag;
`endif

  // Chain of restoring steps; quo doubles as the dividend shift register.
  logic [XLEN:0]   rem_chain [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] quo_chain [BITS_PER_CYCLE+1];

  assign rem_chain[0] = rem_reg;
  assign quo_chain[0] = quo_reg;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    assign shifted          = {rem_chain[gi][XLEN-1:0], quo_chain[gi][XLEN-1]};
    assign diff             = {1'b0, shifted} - {2'b00, dvs_reg};
    assign rem_chain[gi+1]  = diff[XLEN+1] ? shifted : diff[XLEN:0];
    assign quo_chain[gi+1]  = {quo_chain[gi][XLEN-2:0], ~diff[XLEN+1]};
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) state_reg <= DivIdle;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (annul_i) begin
      state_next = DivIdle;
    end else begin
      case (state_reg)
        DivIdle:  if (accept) state_next = special ? DivDone : DivCalc;
        DivCalc:  if (cnt_reg == CNT_W'(1)) state_next = DivFixup;
        DivFixup: state_next = DivDone;
        DivDone:  if (ready_i) state_next = DivIdle;
        default:  state_next = DivIdle;
      endcase
    end
  end

  always_comb begin
    ready_o  = (state_reg == DivIdle);
    valid_o  = (state_reg == DivDone);
    result_o = (state_reg == DivDone) ? result_reg : '0;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      rem_op_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else if (annul_i) begin
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        DivIdle: if (accept) begin
          rem_reg    <= '0;
          quo_reg    <= load_dvd;
          dvs_reg    <= dvs_mag;
          cnt_reg    <= load_iter;
          rem_op_reg <= rem_in;
          neg_q_reg  <= dvd_neg ^ dvs_neg;
          neg_r_reg  <= dvd_neg;
          result_reg <= special ? special_result : '0;
        end
        DivCalc: begin
          rem_reg <= rem_chain[BITS_PER_CYCLE];
          quo_reg <= quo_chain[BITS_PER_CYCLE];
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        DivFixup: begin
          if (rem_op_reg) result_reg <= neg_r_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
          else            result_reg <= neg_q_reg ? -quo_reg : quo_reg;
        end
        DivDone: if (ready_i) result_reg <= '0;
        default: result_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, handshake/flush sequences, random regression.
module tb_div_iter;

  localparam int XLEN = 32;
  localparam int BPC  = 1;

  logic            clk, n_rst_i, valid_i, ready_o, annul_i, valid_o, ready_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i, divisor_i, result_o;

  int total  = 0;
  int passed = 0;

  div_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk_i      (clk),
    .n_rst_i    (n_rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain signed/unsigned arithmetic plus the divide-by-zero rule.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    int bits;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    mag = (!op[0] && a[31]) ? -a : a;
    if (mag == 0) return 1;
    bits = 0;
    while (mag != 0) begin
      bits++;
      mag = mag >> 1;
    end
    return (bits + BPC - 1) / BPC + 2;
`else
    mag = a;
    bits = 0;
    return XLEN / BPC + 2;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op_i = op; dividend_i = a; divisor_i = b; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result_o;
    if (!valid_o) lat = -1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, a, b, exp;
    logic [1:0]  op;
    int lat, seen;

    vecs[0]  = '{2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA};
    vecs[1]  = '{2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE};
    vecs[2]  = '{2'b01, 32'd100, 32'd0, 32'hFFFF_FFFF};
    vecs[3]  = '{2'b11, 32'd100, 32'd0, 32'd100};
    vecs[4]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{2'b01, 32'd7, 32'd2, 32'd3};
    vecs[7]  = '{2'b11, 32'd7, 32'd2, 32'd1};
    vecs[8]  = '{2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[9]  = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1};
    vecs[10] = '{2'b00, 32'd0, 32'd5, 32'd0};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    vecs[12] = '{2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9};
    vecs[13] = '{2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF};
    vecs[14] = '{2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000};
    vecs[15] = '{2'b01, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA};

    n_rst_i = 1'b1; valid_i = 1'b0; annul_i = 1'b0; ready_i = 1'b1;
    op_i = 2'b00; dividend_i = '0; divisor_i = '0;
    #2 n_rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready_o, 1);
    check("reset_valid", valid_o, 0);
    check("reset_result", result_o, 0);
    n_rst_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      $display("vec%0d op=%0d a=%h b=%h -> %h lat=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, ref_latency(vecs[i].op, vecs[i].a, vecs[i].b));
    end

    // Back-pressure: result held while ready_i is low.
    op_i = 2'b01; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd16; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    $display("hold DIVU ffffffff/16 -> %h lat=%0d", result_o, lat);
    check("hold_latency", lat, ref_latency(2'b01, 32'hFFFF_FFFF, 32'd16));
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold_result_c%0d", c), result_o, 32'h0FFF_FFFF);
      check($sformatf("hold_ready_c%0d", c), ready_o, 0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    check("handshake_valid", valid_o, 1);
    check("handshake_ready", ready_o, 0);
    @(negedge clk);
    check("post_handshake_valid", valid_o, 0);
    check("post_handshake_ready", ready_o, 1);
    check("post_handshake_result", result_o, 0);

    // Flush in the tenth CALC cycle.
    op_i = 2'b01; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd3; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_ready", ready_o, 1);
    check("annul_valid", valid_o, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    $display("annul in CALC: valid seen=%0d", seen);
    check("annul_no_valid", seen, 0);
    run_op(2'b01, 32'd7, 32'd2, res, lat);
    $display("post-annul DIVU 7/2 -> %h lat=%0d", res, lat);
    check("post_annul_result", res, 3);
    check("post_annul_latency", lat, ref_latency(2'b01, 32'd7, 32'd2));

    // Flush overrides a same-cycle accept.
    op_i = 2'b01; dividend_i = 32'd7; divisor_i = 32'd2; valid_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; annul_i = 1'b0;
    $display("annul with accept: ready=%0d", ready_o);
    check("annul_accept_ready", ready_o, 1);

    // Flush in DONE while the consumer stalls.
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd0; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    check("done_flush_pre_result", result_o, 32'hFFFF_FFFF);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; ready_i = 1'b1;
    $display("annul in DONE: valid=%0d result=%h ready=%0d", valid_o, result_o, ready_o);
    check("done_flush_valid", valid_o, 0);
    check("done_flush_result", result_o, 0);
    check("done_flush_ready", ready_o, 1);

    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      exp = ref_result(op, a, b);
      run_op(op, a, b, res, lat);
      $display("rand%0d op=%0d a=%h b=%h -> %h (exp %h) lat=%0d", n, op, a, b, res, exp, lat);
      check($sformatf("rand%0d_result", n), res, exp);
      check($sformatf("rand%0d_latency", n), lat, ref_latency(op, a, b));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
